// File: rtl/mux_16_rr_arbiter.sv
// Round-robin arbiter steering a 16:1 data mux, with bounded bursts and a valid/ready output.
// Optional build macro MUX_ARB_TIMEOUT_EN adds a forced release after TIMEOUT_CYCLES stalled cycles.
module mux_16_rr_arbiter #(
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req,
    input  logic        out_ready,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        out_valid,
    output logic        busy,
    output logic        timeout
);

    // Handshake: a beat transfers on every rising clk edge where out_valid && out_ready.
    typedef enum logic {IDLE, GRANT} state_t;

    state_t      state_q, state_d;
    logic [15:0] grant_q, grant_d;
    logic [3:0]  sel_q, sel_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;
    logic        timeout_q, timeout_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  beat_q, beat_d;

    logic        accept, req_w, last_beat, to_hit, rel, grant_load;
    logic [3:0]  arb_start;
    logic [4:0]  win;

    // Returns {found, index} of the first set bit scanning start, start+1, ... mod 16.
    function automatic logic [4:0] pick(input logic [15:0] r, input logic [3:0] start);
        logic [4:0] res;
        logic [3:0] idx;
        res = '0;
        for (int i = 15; i >= 0; i--) begin
            idx = start + 4'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign accept    = out_valid_q && out_ready;
    assign req_w     = req[sel_q];
    assign last_beat = (beat_q == 8'(MAX_BURST - 1));
    assign arb_start = (state_q == GRANT) ? sel_q + 4'd1 : ptr_q;
    assign win       = pick(req, arb_start);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        ptr_d       = ptr_q;
        beat_d      = beat_q;
        timeout_d   = 1'b0;
        grant_load  = 1'b0;
        rel         = 1'b0;
        case (state_q)
            IDLE: begin
                if (win[4]) grant_load = 1'b1;
            end
            GRANT: begin
                // Dropping the request releases whether or not a beat moved this cycle.
                rel = !req_w || (accept && last_beat) || to_hit;
                if (rel) begin
                    ptr_d     = sel_q + 4'd1;
                    timeout_d = to_hit;
                    if (win[4]) begin
                        grant_load = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        out_valid_d = 1'b0;
                        busy_d      = 1'b0;
                        beat_d      = '0;
                    end
                end else if (accept) begin
                    beat_d = beat_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_load) begin
            state_d     = GRANT;
            grant_d     = 16'd1 << win[3:0];
            sel_d       = win[3:0];
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
            beat_d      = '0;
        end
    end

`ifdef MUX_ARB_TIMEOUT_EN
    logic [15:0] wait_q;

    assign to_hit = out_valid_q && !out_ready && (wait_q == 16'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (grant_load || accept || !out_valid_d) begin
            wait_q <= '0;
        end else if (out_valid_q && !out_ready) begin
            wait_q <= wait_q + 16'd1;
        end
    end
`else
    // No wait counter in this build; the parameter stays so both builds share one instantiation.
    assign to_hit = 1'b0 && (TIMEOUT_CYCLES < 1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= '0;
            beat_q      <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
        end
    end

    assign grant     = grant_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux_16_rr_arbiter.sv
// Directed bench for mux_16_rr_arbiter: a MAX_BURST=4 instance and a MAX_BURST=1 instance.
module tb_mux_16_rr_arbiter;

    logic        clk, rst_n;
    logic [15:0] req, req1;
    logic        out_ready, out_ready1;
    logic [15:0] grant, grant1;
    logic [3:0]  sel, sel1;
    logic        out_valid, out_valid1, busy, busy1, timeout, timeout1;

    int n_vec = 0;
    int n_err = 0;

    mux_16_rr_arbiter #(.MAX_BURST(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .out_ready(out_ready),
        .grant(grant), .sel(sel), .out_valid(out_valid), .busy(busy), .timeout(timeout)
    );

    mux_16_rr_arbiter #(.MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .out_ready(out_ready1),
        .grant(grant1), .sel(sel1), .out_valid(out_valid1), .busy(busy1), .timeout(timeout1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_grant(input string tag, input logic [15:0] g, input logic [3:0] s);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".sel"}, 32'(sel), 32'(s));
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    task automatic expect_idle(input string tag, input logic [3:0] s);
        check({tag, ".grant"}, 32'(grant), 32'd0);
        check({tag, ".sel"}, 32'(sel), 32'(s));
        check({tag, ".valid"}, 32'(out_valid), 32'd0);
        check({tag, ".busy"}, 32'(busy), 32'd0);
    endtask

    task automatic hold(input string tag, input int n, input logic [15:0] g, input logic [3:0] s);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_grant(tag, g, s);
        end
    endtask

    initial begin
        rst_n = 1'b0; req = '0; req1 = '0; out_ready = 1'b0; out_ready1 = 1'b0;
        repeat (3) tick();
        expect_idle("reset", 4'd0);
        check("reset.timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_idle("idle", 4'd0);
        end

        // single requester 5, four beats, leaves ptr at 6
        req = 16'h0020; out_ready = 1'b1;
        tick();
        expect_grant("single", 16'h0020, 4'd5);
        hold("single_beats", 3, 16'h0020, 4'd5);
        req = 16'h0000;
        tick();
        expect_idle("single_rel", 4'd5);

        // ptr=6 picks 6 over 0; burst limit hands over with no gap
        req = 16'h0041;
        tick();
        expect_grant("ptr6", 16'h0040, 4'd6);
        hold("burst6", 3, 16'h0040, 4'd6);
        tick();
        expect_grant("b2b_0", 16'h0001, 4'd0);
        hold("burst0", 3, 16'h0001, 4'd0);
        tick();
        expect_grant("b2b_6", 16'h0040, 4'd6);

        // aborts steer ptr to 14, then wrap order 14, 0, 1
        req = 16'h2000;
        tick();
        expect_grant("abort_13", 16'h2000, 4'd13);
        req = 16'h4003;
        tick();
        expect_grant("wrap14", 16'h4000, 4'd14);
        hold("wrap14_b", 3, 16'h4000, 4'd14);
        tick();
        expect_grant("wrap0", 16'h0001, 4'd0);
        hold("wrap0_b", 3, 16'h0001, 4'd0);
        tick();
        expect_grant("wrap1", 16'h0002, 4'd1);
        req = 16'h0000;
        tick();
        expect_idle("wrap_end", 4'd1);

        // backpressure, then abort of requester 3
        req = 16'h0008; out_ready = 1'b0;
        tick();
        expect_grant("bp3", 16'h0008, 4'd3);
        req = 16'h0408;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_grant("bp3_stall", 16'h0008, 4'd3);
            check("bp3_timeout", 32'(timeout), 32'd0);
        end
        req = 16'h0400;
        tick();
        expect_grant("bp_abort", 16'h0400, 4'd10);
        hold("bp10_stall", 2, 16'h0400, 4'd10);
        // stalled cycles counted no beats: still exactly four beats for 10
        req = 16'h0401; out_ready = 1'b1;
        hold("bp10_beats", 3, 16'h0400, 4'd10);
        tick();
        expect_grant("bp_next0", 16'h0001, 4'd0);
        req = 16'h0000;
        tick();
        expect_idle("bp_end", 4'd0);

        // full contention on the MAX_BURST=1 instance
        req1 = 16'hFFFF; out_ready1 = 1'b1;
        tick();
        check("rot.sel0", 32'(sel1), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            tick();
            check("rot.sel", 32'(sel1), 32'(i % 16));
            check("rot.grant", 32'(grant1), 32'(16'd1 << (i % 16)));
            check("rot.busy", 32'(busy1), 32'd1);
        end
        req1 = 16'h0000;
        tick();
        check("rot_end.busy", 32'(busy1), 32'd0);
        check("rot_end.grant", 32'(grant1), 32'd0);

        // asynchronous reset mid-burst
        req = 16'h0100; out_ready = 1'b0;
        tick();
        expect_grant("mid", 16'h0100, 4'd8);
        out_ready = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        expect_idle("async_rst", 4'd0);
        tick();
        rst_n = 1'b1; req = 16'h0000; out_ready = 1'b0;
        tick();
        expect_idle("post_rst", 4'd0);

`ifdef MUX_ARB_TIMEOUT_EN
        req = 16'h0101;
        tick();
        expect_grant("to_g0", 16'h0001, 4'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            expect_grant("to_wait", 16'h0001, 4'd0);
            check("to_wait.pulse", 32'(timeout), 32'd0);
        end
        tick();
        expect_grant("to_g8", 16'h0100, 4'd8);
        check("to_pulse", 32'(timeout), 32'd1);
        tick();
        check("to_pulse_end", 32'(timeout), 32'd0);
        expect_grant("to_hold8", 16'h0100, 4'd8);
        req = 16'h0000;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
